// File: rtl/sa_seq_pkg.sv
// Shared types and constant helpers for the systolic-array sequencer.
// Widths are derived from the array geometry at elaboration time.
package sa_seq_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        FEED  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic int max_i(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // One down-counter covers both FEED (K cycles) and DRAIN (M+N-1 cycles).
    function automatic int cnt_width(input int k, input int m, input int n);
        int span;
        span = max_i(k, m + n - 1);
        return (span > 1) ? $clog2(span) : 1;
    endfunction

    function automatic int idx_width(input int k);
        return (k > 1) ? $clog2(k) : 1;
    endfunction

    function automatic int lane_lsb(input int lane, input int dw);
        return lane * dw;
    endfunction

endpackage

// File: rtl/sa_skew_line.sv
// DEPTH-stage data+valid delay line used to skew one array edge lane.
// DEPTH=0 is a straight wire.
module sa_skew_line #(
    parameter int DEPTH      = 1,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_vld,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_vld
);

    if (DEPTH == 0) begin : g_pass
        logic w_unused_clk_rst;
        assign w_unused_clk_rst = clk ^ reset;
        assign o_data = i_data;
        assign o_vld  = i_vld;
    end else begin : g_regs
        logic [DEPTH-1:0][DATA_WIDTH-1:0] r_data;
        logic [DEPTH-1:0]                 r_vld;

        always_ff @(posedge clk) begin
            if (reset) begin
                r_data <= '0;
                r_vld  <= '0;
            end else begin
                r_data[0] <= i_data;
                r_vld[0]  <= i_vld;
                for (int s = 1; s < DEPTH; s++) begin
                    r_data[s] <= r_data[s-1];
                    r_vld[s]  <= r_vld[s-1];
                end
            end
        end

        assign o_data = r_data[DEPTH-1];
        assign o_vld  = r_vld[DEPTH-1];
    end

endmodule

// File: rtl/sa_sequencer.sv
// Job sequencer for the MxN systolic MAC array: clear, stream K operand slices
// with diagonal skew, wait for the wavefront to reach the far corner, pulse done.
module sa_sequencer
    import sa_seq_pkg::*;
#(
    parameter  int M          = 4,
    parameter  int N          = 4,
    parameter  int K          = 4,
    parameter  int DATA_WIDTH = 8,
    localparam int KW         = idx_width(K),
    localparam int CW         = cnt_width(K, M, N)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    clear_acc,
    output logic                    a_rd_en,
    output logic [KW-1:0]           a_rd_k,
    input  logic [M*DATA_WIDTH-1:0] a_rd_data,
    output logic                    b_rd_en,
    output logic [KW-1:0]           b_rd_k,
    input  logic [N*DATA_WIDTH-1:0] b_rd_data,
    output logic [M*DATA_WIDTH-1:0] a_feed,
    output logic [M-1:0]            a_feed_vld,
    output logic [N*DATA_WIDTH-1:0] b_feed,
    output logic [N-1:0]            b_feed_vld
);

    state_t        r_state;
    state_t        w_next;
    logic [CW-1:0] r_cnt;
    logic          w_cnt_zero;
    logic [KW-1:0] w_rd_k;
    logic          r_rd_vld;

    assign w_cnt_zero = (r_cnt == '0);
    // Counter runs down, slice index runs up.
    assign w_rd_k     = KW'(CW'(K - 1) - r_cnt);

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    if (start) w_next = CLEAR;
            CLEAR:   w_next = FEED;
            FEED:    if (w_cnt_zero) w_next = DRAIN;
            DRAIN:   if (w_cnt_zero) w_next = DONE;
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state != IDLE);
        done      = (r_state == DONE);
        clear_acc = (r_state == CLEAR);
        a_rd_en   = (r_state == FEED);
        b_rd_en   = (r_state == FEED);
        a_rd_k    = (r_state == FEED) ? w_rd_k : '0;
        b_rd_k    = (r_state == FEED) ? w_rd_k : '0;
    end

    // Reloaded on entry to FEED (K-1) and DRAIN (M+N-2); holds at zero elsewhere.
    always_ff @(posedge clk) begin
        if (reset)                            r_cnt <= '0;
        else if (r_state == CLEAR)            r_cnt <= CW'(K - 1);
        else if (r_state == FEED && w_cnt_zero) r_cnt <= CW'(M + N - 2);
        else if (!w_cnt_zero)                 r_cnt <= r_cnt - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) r_rd_vld <= 1'b0;
        else       r_rd_vld <= (r_state == FEED);
    end

    for (genvar i = 0; i < M; i++) begin : g_a
        logic [DATA_WIDTH-1:0] w_d;
        logic                  w_v;
        sa_skew_line #(.DEPTH(i), .DATA_WIDTH(DATA_WIDTH)) u_skew (
            .clk    (clk),
            .reset  (reset),
            .i_data (a_rd_data[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH]),
            .i_vld  (r_rd_vld),
            .o_data (w_d),
            .o_vld  (w_v)
        );
        // Invalid lanes present zero so the array MACs nothing.
        assign a_feed[lane_lsb(i, DATA_WIDTH) +: DATA_WIDTH] = w_v ? w_d : '0;
        assign a_feed_vld[i] = w_v;
    end

    for (genvar j = 0; j < N; j++) begin : g_b
        logic [DATA_WIDTH-1:0] w_d;
        logic                  w_v;
        sa_skew_line #(.DEPTH(j), .DATA_WIDTH(DATA_WIDTH)) u_skew (
            .clk    (clk),
            .reset  (reset),
            .i_data (b_rd_data[lane_lsb(j, DATA_WIDTH) +: DATA_WIDTH]),
            .i_vld  (r_rd_vld),
            .o_data (w_d),
            .o_vld  (w_v)
        );
        assign b_feed[lane_lsb(j, DATA_WIDTH) +: DATA_WIDTH] = w_v ? w_d : '0;
        assign b_feed_vld[j] = w_v;
    end

endmodule
